// File: rtl/lifo_stack.sv
// lifo_stack: synchronous LIFO of DEPTH words with registered pop data and status/error flags
//   clk       rising-edge clock for all state
//   reset     synchronous active-high clear (sp, data_out, error flags)
//   push      write data_in on top of stack
//   pop       remove top entry and present it on data_out
//   data_in   word to push
//   data_out  registered value of the last popped word
//   empty     count == 0
//   full      count == DEPTH
//   count     number of stored entries, 0..DEPTH
//   overflow  one-cycle pulse: push rejected because full
//   underflow one-cycle pulse: pop rejected because empty
module lifo_stack #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  empty,
    output logic                  full,
    output logic [AW:0]           count,
    output logic                  overflow,
    output logic                  underflow
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW:0]           sp;
    logic [AW-1:0]         top;
    logic [AW-1:0]         wr_addr;
    logic                  wr_en;

    assign count = sp;
    assign empty = sp == '0;
    assign full  = sp == (AW+1)'(DEPTH);
    assign top   = AW'(sp - 1'b1);

    // Push+pop overwrites the current top in place; a plain push appends at sp.
    assign wr_en   = push && (pop ? !empty : !full);
    assign wr_addr = pop ? top : sp[AW-1:0];

    always_ff @(posedge clk) begin
        if (wr_en && !reset)
            mem[wr_addr] <= data_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sp        <= '0;
            data_out  <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= push && !pop && full;
            underflow <= pop && !push && empty;
            if (push && pop)
                data_out <= empty ? data_in : mem[top];
            else if (push && !full)
                sp <= sp + 1'b1;
            else if (pop && !empty) begin
                data_out <= mem[top];
                sp       <= sp - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_lifo_stack.sv
// tb_lifo_stack: directed self-checking bench for lifo_stack
module tb_lifo_stack;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic [7:0] data_in = '0;
    logic [7:0] data_out;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;
    int         checks = 0;
    int         failures = 0;

    lifo_stack #(.DATA_WIDTH(8), .DEPTH(16)) dut (
        .clk(clk),
        .reset(reset),
        .push(push),
        .pop(pop),
        .data_in(data_in),
        .data_out(data_out),
        .empty(empty),
        .full(full),
        .count(count),
        .overflow(overflow),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic step(input logic ps, input logic pp, input logic [7:0] d);
        push = ps;
        pop = pp;
        data_in = d;
        @(posedge clk);
        #1;
        push = 1'b0;
        pop = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        step(1'b1, 1'b0, 8'hFF);
        reset = 1'b0;
        check("rst_count", 32'(count), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_dout", 32'(data_out), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_udf", 32'(underflow), 0);

        step(1'b1, 1'b0, 8'hA4);
        check("push_count", 32'(count), 1);
        check("push_empty", 32'(empty), 0);
        step(1'b0, 1'b1, 8'h00);
        check("pop_dout", 32'(data_out), 32'hA4);
        check("pop_empty", 32'(empty), 1);
        step(1'b0, 1'b0, 8'h00);
        check("idle_hold", 32'(data_out), 32'hA4);
        step(1'b1, 1'b0, 8'hC2);
        step(1'b0, 1'b1, 8'h00);
        check("pop2_dout", 32'(data_out), 32'hC2);
        check("pop2_empty", 32'(empty), 1);

        for (int i = 1; i <= 16; i++)
            step(1'b1, 1'b0, 8'(i));
        check("fill_full", 32'(full), 1);
        check("fill_count", 32'(count), 16);
        step(1'b1, 1'b0, 8'h55);
        check("ovf_pulse", 32'(overflow), 1);
        check("ovf_count", 32'(count), 16);
        step(1'b1, 1'b1, 8'hAA);
        check("full_rep_dout", 32'(data_out), 16);
        check("full_rep_ovf", 32'(overflow), 0);
        check("full_rep_count", 32'(count), 16);
        step(1'b0, 1'b1, 8'h00);
        check("full_rep_pop", 32'(data_out), 32'hAA);
        check("pop_not_full", 32'(full), 0);
        for (int i = 15; i >= 1; i--) begin
            step(1'b0, 1'b1, 8'h00);
            check($sformatf("lifo_%0d", i), 32'(data_out), 32'(i));
        end
        check("drain_empty", 32'(empty), 1);

        step(1'b0, 1'b1, 8'h00);
        check("udf_pulse", 32'(underflow), 1);
        check("udf_dout", 32'(data_out), 1);
        check("udf_count", 32'(count), 0);
        step(1'b0, 1'b0, 8'h00);
        check("udf_clear", 32'(underflow), 0);

        step(1'b1, 1'b0, 8'h11);
        step(1'b1, 1'b0, 8'h22);
        step(1'b1, 1'b1, 8'h33);
        check("rep_dout", 32'(data_out), 32'h22);
        check("rep_count", 32'(count), 2);
        check("rep_flags", {30'b0, overflow, underflow}, 0);
        step(1'b0, 1'b1, 8'h00);
        check("rep_pop", 32'(data_out), 32'h33);
        step(1'b0, 1'b1, 8'h00);
        check("rep_pop2", 32'(data_out), 32'h11);
        step(1'b1, 1'b1, 8'h77);
        check("pass_dout", 32'(data_out), 32'h77);
        check("pass_empty", 32'(empty), 1);
        check("pass_flags", {30'b0, overflow, underflow}, 0);

        step(1'b1, 1'b0, 8'h01);
        step(1'b1, 1'b0, 8'h02);
        step(1'b1, 1'b0, 8'h03);
        step(1'b0, 1'b1, 8'h00);
        check("pre_rst_dout", 32'(data_out), 3);
        reset = 1'b1;
        step(1'b0, 1'b0, 8'h00);
        reset = 1'b0;
        check("mid_rst_count", 32'(count), 0);
        check("mid_rst_dout", 32'(data_out), 0);
        step(1'b1, 1'b0, 8'h9E);
        check("post_rst_count", 32'(count), 1);
        step(1'b0, 1'b1, 8'h00);
        check("post_rst_pop", 32'(data_out), 32'h9E);
        check("post_rst_empty", 32'(empty), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
